projectile_ctl: RTL and testbench

Generic projectile flight controller for the turn-based throw game. One instance per player (cat, dog) is parameterised for launch origin, throw direction, wall and target boxes. It replaces the per-player throw controllers. Each physics tick it integrates velocity incrementally, takes a live wind input latched at launch, and reports a one-shot outcome: target hit, wall top, or miss.

---
 rtl/projectile_ctl_if.sv | 25 ++
 rtl/projectile_ctl.sv | 185 ++++++++++++++++++
 tb/tb_projectile_ctl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/projectile_ctl_if.sv
// Control and status bundle for one projectile flight controller.
// The master modport drives launch requests; the slave modport reports flight state.
interface projectile_ctl_if;
  logic               enable;
  logic               abort;
  logic [9:0]         throw_force;
  logic [6:0]         wind;
  logic signed [11:0] x_pos;
  logic signed [11:0] y_pos;
  logic               busy;
  logic               hit_target;
  logic               hit_wall;
  logic               missed;
  logic [1:0]         outcome;

  modport master (
    output enable, abort, throw_force, wind,
    input  x_pos, y_pos, busy, hit_target, hit_wall, missed, outcome
  );

  modport slave (
    input  enable, abort, throw_force, wind,
    output x_pos, y_pos, busy, hit_target, hit_wall, missed, outcome
  );
endinterface

// File: rtl/projectile_ctl.sv
// Per-player projectile flight controller: tick-based ballistic integration,
// wind-adjusted launch velocity and a one-shot target/wall/miss outcome.
module projectile_ctl #(
  parameter int TICK_DIV      = 1300000,
  parameter int ORIGIN_X      = 140,
  parameter int ORIGIN_Y      = 350,
  parameter int DIR           = 1,
  parameter int INIT_VELOCITY = 27,
  parameter int GRAVITY       = 1,
  parameter int FORCE_PCT     = 18,
  parameter int SCREEN_H      = 768,
  parameter int SCREEN_W      = 1024,
  parameter int GROUND_Y      = 243,
  parameter int WALL_XL       = 490,
  parameter int WALL_XR       = 534,
  parameter int WALL_TOP      = 241,
  parameter int MARGIN        = 15,
  parameter int TGT_XL        = 867,
  parameter int TGT_XR        = 1024,
  parameter int TGT_TOP       = 427,
  parameter int TGT_BOT       = 525
) (
  input  logic              clk,
  input  logic              rst_n,
  projectile_ctl_if.slave   bus
);

  localparam int unsigned CW = 32;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam int SPAN_L  = WALL_XL - MARGIN;
  localparam int SPAN_R  = WALL_XR + MARGIN;
  localparam int WTOP_LO = WALL_TOP - MARGIN;

  localparam logic [1:0] OUT_NONE   = 2'b00;
  localparam logic [1:0] OUT_TARGET = 2'b01;
  localparam logic [1:0] OUT_WALL   = 2'b10;
  localparam logic [1:0] OUT_MISS   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_FLIGHT, S_END} state_e;

  state_e               state_q, state_d;
  logic signed [CW-1:0] x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [1:0]           outcome_q, outcome_d;
  logic                 busy_q, busy_d;
  logic                 hit_t_q, hit_t_d, hit_w_q, hit_w_d, miss_q, miss_d;

  logic [6:0]           wind_lim;
  logic signed [CW-1:0] force_s, wind_s, vx_mag, vx_launch;
  logic signed [CW-1:0] scr_y, x_nxt, y_nxt, scr_y_nxt;
  logic                 tick, blocked, in_tgt, on_wall, on_ground, off_scr;

  // Launch velocity and per-cycle collision predicates on the registered position.
  always_comb begin
    wind_lim  = (bus.wind > 7'd100) ? 7'd100 : bus.wind;
    force_s   = CW'(bus.throw_force);
    wind_s    = CW'(wind_lim);
    vx_mag    = (force_s * FORCE_PCT) / 100 + ((wind_s - 50) * force_s) / 50;
    vx_launch = (DIR < 0) ? -vx_mag : vx_mag;

    tick      = (cnt_q == TICK_LAST);
    scr_y     = SCREEN_H - y_q;
    x_nxt     = x_q + vx_q;
    y_nxt     = y_q + vy_q;
    scr_y_nxt = SCREEN_H - y_nxt;
    blocked   = (x_nxt >= SPAN_L) && (x_nxt <= SPAN_R) && (scr_y_nxt > WALL_TOP);

    in_tgt    = (x_q >= TGT_XL) && (x_q <= TGT_XR) && (scr_y >= TGT_TOP) && (scr_y <= TGT_BOT);
    on_wall   = (x_q >= SPAN_L) && (x_q <= SPAN_R) && (scr_y >= WTOP_LO) &&
                (scr_y <= WALL_TOP) && (vy_q <= 0);
    on_ground = (y_q <= GROUND_Y) && (vy_q < 0);
    off_scr   = (x_q < 0) || (x_q >= SCREEN_W);
  end

  // Next-state and datapath; abort outranks every collision check.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    cnt_d     = cnt_q;
    outcome_d = outcome_q;
    hit_t_d   = 1'b0;
    hit_w_d   = 1'b0;
    miss_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        x_d = CW'(ORIGIN_X);
        y_d = CW'(ORIGIN_Y);
        if (bus.enable) begin
          vx_d      = vx_launch;
          vy_d      = CW'(INIT_VELOCITY);
          cnt_d     = '0;
          outcome_d = OUT_NONE;
          state_d   = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        if (bus.abort) begin
          x_d       = CW'(ORIGIN_X);
          y_d       = CW'(ORIGIN_Y);
          outcome_d = OUT_NONE;
          state_d   = S_IDLE;
        end else if (in_tgt) begin
          outcome_d = OUT_TARGET;
          hit_t_d   = 1'b1;
          state_d   = S_END;
        end else if (on_wall) begin
          outcome_d = OUT_WALL;
          hit_w_d   = 1'b1;
          state_d   = S_END;
        end else if (on_ground) begin
          y_d       = CW'(GROUND_Y);
          outcome_d = OUT_MISS;
          miss_d    = 1'b1;
          state_d   = S_END;
        end else if (off_scr) begin
          outcome_d = OUT_MISS;
          miss_d    = 1'b1;
          state_d   = S_END;
        end else if (tick) begin
          cnt_d = '0;
          y_d   = y_nxt;
          vy_d  = vy_q - GRAVITY;
          // A blocked move pins x against the wall face for the rest of the flight.
          if (blocked) begin
            vx_d = '0;
          end else begin
            x_d = x_nxt;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_END: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FLIGHT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= CW'(ORIGIN_X);
      y_q       <= CW'(ORIGIN_Y);
      vx_q      <= '0;
      vy_q      <= '0;
      cnt_q     <= '0;
      outcome_q <= OUT_NONE;
      busy_q    <= 1'b0;
      hit_t_q   <= 1'b0;
      hit_w_q   <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      cnt_q     <= cnt_d;
      outcome_q <= outcome_d;
      busy_q    <= busy_d;
      hit_t_q   <= hit_t_d;
      hit_w_q   <= hit_w_d;
      miss_q    <= miss_d;
    end
  end

  assign bus.x_pos      = 12'(x_q);
  assign bus.y_pos      = 12'(y_q);
  assign bus.busy       = busy_q;
  assign bus.hit_target = hit_t_q;
  assign bus.hit_wall   = hit_w_q;
  assign bus.missed     = miss_q;
  assign bus.outcome    = outcome_q;

endmodule

// File: tb/tb_projectile_ctl.sv
// Directed bench for projectile_ctl: outcome pulses are scoreboarded by a monitor,
// positions and status are compared at tick boundaries by the stimulus process.
module tb_projectile_ctl;

  logic clk;
  logic rst_n;

  projectile_ctl_if bus0 ();
  projectile_ctl_if bus1 ();
  projectile_ctl_if bus2 ();

  projectile_ctl #(.TICK_DIV(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  projectile_ctl #(.TICK_DIV(4), .DIR(-1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  projectile_ctl #(.TICK_DIV(4), .TGT_XL(130), .TGT_XR(150), .TGT_TOP(380), .TGT_BOT(400))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         dut;
    logic [1:0] oc;
    int         x;
    int         y;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [2:0]         pulse [3];
  logic [1:0]         oc    [3];
  logic signed [11:0] xs    [3];
  logic signed [11:0] ys    [3];
  logic [2:0]         busy_v;

  assign pulse[0] = {bus0.hit_target, bus0.hit_wall, bus0.missed};
  assign pulse[1] = {bus1.hit_target, bus1.hit_wall, bus1.missed};
  assign pulse[2] = {bus2.hit_target, bus2.hit_wall, bus2.missed};
  assign oc[0] = bus0.outcome;
  assign oc[1] = bus1.outcome;
  assign oc[2] = bus2.outcome;
  assign xs[0] = bus0.x_pos;
  assign xs[1] = bus1.x_pos;
  assign xs[2] = bus2.x_pos;
  assign ys[0] = bus0.y_pos;
  assign ys[1] = bus1.y_pos;
  assign ys[2] = bus2.y_pos;
  assign busy_v = {bus2.busy, bus1.busy, bus0.busy};

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [2:0] onehot(input logic [1:0] o);
    case (o)
      2'b01:   return 3'b100;
      2'b10:   return 3'b010;
      2'b11:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Monitor: every outcome pulse must match the oldest expected outcome.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (pulse[d] != 3'b000) begin
          if (sb.size() == 0) begin
            check("spurious_pulse", 32'(pulse[d]), 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_dut", d, e.dut);
            check("sb_pulse", 32'(pulse[d]), 32'(onehot(e.oc)));
            check("sb_outcome", 32'(oc[d]), 32'(e.oc));
            check("sb_x", 32'(xs[d]), e.x);
            check("sb_y", 32'(ys[d]), e.y);
          end
        end
      end
    end
  end

  task automatic drive(input int d, input logic en, input logic ab,
                       input logic [9:0] f, input logic [6:0] w);
    case (d)
      0: begin bus0.enable = en; bus0.abort = ab; bus0.throw_force = f; bus0.wind = w; end
      1: begin bus1.enable = en; bus1.abort = ab; bus1.throw_force = f; bus1.wind = w; end
      default: begin bus2.enable = en; bus2.abort = ab; bus2.throw_force = f; bus2.wind = w; end
    endcase
  endtask

  // Raises enable and returns at the first sample after the launch edge.
  task automatic launch(input int d, input logic [9:0] f, input logic [6:0] w);
    drive(d, 1'b1, 1'b0, f, w);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n;
    n = 0;
    while (busy_v[d] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy_v[d]) check("timeout", 1, 0);
  endtask

  task automatic stop_and_idle(input int d);
    drive(d, 1'b0, 1'b1, 10'd0, 7'd50);
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 10'd0, 7'd50);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 10'd0, 7'd50);
    repeat (2) @(negedge clk);
    check("rst_x", 32'(bus0.x_pos), 140);
    check("rst_y", 32'(bus0.y_pos), 350);
    check("rst_busy", 32'(bus0.busy), 0);
    check("rst_outcome", 32'(bus0.outcome), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vertical throw to the ground.
    launch(0, 10'd0, 7'd50);
    check("vert_busy", 32'(bus0.busy), 1);
    check("vert_y0", 32'(bus0.y_pos), 350);
    repeat (4) @(negedge clk);
    check("vert_y1", 32'(bus0.y_pos), 377);
    check("vert_x1", 32'(bus0.x_pos), 140);
    repeat (104) @(negedge clk);
    check("vert_apex", 32'(bus0.y_pos), 728);
    sb.push_back('{dut: 0, oc: 2'b11, x: 140, y: 243});
    wait_idle(0, 400);
    check("vert_outcome", 32'(bus0.outcome), 3);
    @(negedge clk);
    check("vert_pulse_width", 32'(bus0.missed), 0);

    // Enable held high through END must not relaunch.
    repeat (3) @(negedge clk);
    check("rearm_hold_busy", 32'(bus0.busy), 0);
    check("rearm_hold_y", 32'(bus0.y_pos), 243);
    check("rearm_hold_outcome", 32'(bus0.outcome), 3);
    drive(0, 1'b0, 1'b0, 10'd0, 7'd50);
    @(negedge clk);
    launch(0, 10'd0, 7'd50);
    check("rearm_busy", 32'(bus0.busy), 1);
    check("rearm_outcome", 32'(bus0.outcome), 0);
    check("rearm_y", 32'(bus0.y_pos), 350);

    // Abort at tick 5: back to origin, no pulse.
    repeat (20) @(negedge clk);
    check("abort_y5", 32'(bus0.y_pos), 475);
    drive(0, 1'b0, 1'b1, 10'd0, 7'd50);
    @(negedge clk);
    check("abort_busy", 32'(bus0.busy), 0);
    check("abort_x", 32'(bus0.x_pos), 140);
    check("abort_y", 32'(bus0.y_pos), 350);
    check("abort_outcome", 32'(bus0.outcome), 0);
    drive(0, 1'b0, 1'b0, 10'd0, 7'd50);
    repeat (2) @(negedge clk);

    // Horizontal speed, neutral wind.
    launch(0, 10'd100, 7'd50);
    repeat (4) @(negedge clk);
    check("h18_x1", 32'(bus0.x_pos), 158);
    repeat (4) @(negedge clk);
    check("h18_x2", 32'(bus0.x_pos), 176);
    stop_and_idle(0);

    // Wind above 100 saturates at 100.
    launch(0, 10'd100, 7'd127);
    repeat (4) @(negedge clk);
    check("wind_clamp_x1", 32'(bus0.x_pos), 258);
    stop_and_idle(0);

    // Negative wind term truncates toward zero.
    launch(0, 10'd7, 7'd49);
    repeat (4) @(negedge clk);
    check("trunc_x1", 32'(bus0.x_pos), 141);
    stop_and_idle(0);

    // Full headwind: x leaves the screen on tick 2.
    launch(0, 10'd100, 7'd0);
    repeat (4) @(negedge clk);
    check("h82_x1", 32'(bus0.x_pos), 58);
    sb.push_back('{dut: 0, oc: 2'b11, x: -24, y: 403});
    wait_idle(0, 50);
    check("h82_outcome", 32'(bus0.outcome), 3);
    drive(0, 1'b0, 1'b0, 10'd0, 7'd50);
    repeat (2) @(negedge clk);

    // Wall blocks the fourth move, flight ends on the ground.
    launch(0, 10'd500, 7'd50);
    repeat (12) @(negedge clk);
    check("wall_x3", 32'(bus0.x_pos), 410);
    repeat (4) @(negedge clk);
    check("wall_x4", 32'(bus0.x_pos), 410);
    check("wall_y4", 32'(bus0.y_pos), 452);
    sb.push_back('{dut: 0, oc: 2'b11, x: 410, y: 243});
    wait_idle(0, 400);
    check("wall_outcome", 32'(bus0.outcome), 3);
    drive(0, 1'b0, 1'b0, 10'd0, 7'd50);
    repeat (2) @(negedge clk);

    // Left-throwing instance.
    launch(1, 10'd100, 7'd50);
    repeat (4) @(negedge clk);
    check("left_x1", 32'(bus1.x_pos), 122);
    repeat (4) @(negedge clk);
    check("left_x2", 32'(bus1.x_pos), 104);
    stop_and_idle(1);

    // Target box around the first tick position.
    launch(2, 10'd0, 7'd50);
    repeat (4) @(negedge clk);
    check("tgt_y1", 32'(bus2.y_pos), 377);
    sb.push_back('{dut: 2, oc: 2'b01, x: 140, y: 377});
    wait_idle(2, 10);
    check("tgt_outcome", 32'(bus2.outcome), 1);
    @(negedge clk);
    check("tgt_pulse_width", 32'(bus2.hit_target), 0);
    check("tgt_hold_x", 32'(bus2.x_pos), 140);
    check("tgt_hold_y", 32'(bus2.y_pos), 377);
    drive(2, 1'b0, 1'b0, 10'd0, 7'd50);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-flight.
    launch(0, 10'd100, 7'd50);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 10'd0, 7'd50);
    #1;
    check("arst_busy", 32'(bus0.busy), 0);
    check("arst_x", 32'(bus0.x_pos), 140);
    check("arst_y", 32'(bus0.y_pos), 350);
    check("arst_outcome", 32'(bus0.outcome), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("sb_leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
